conv1d_engine: RTL and testbench

Parametrised 1-D convolution datapath for the next-generation convolution coprocessor. It generalises the fixed-kernel Y→Z engine: both the signal Y and the kernel H come from host-loaded memories with runtime lengths, and each result is written to the Z memory. Accumulation is selectable between wrapping and saturating. It sits below the AIP host wrapper, which owns the memories, the STATUS/interrupt logic and the config registers, and drives `start`, the sizes and `sat_mode`.

---
 rtl/conv_pkg.sv | 11 +
 rtl/conv_mac.sv | 39 +++
 rtl/conv1d_engine.sv | 114 +++++++++++
 tb/tb_conv1d_engine.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, default sizing and size validation for conv1d_engine.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_Y_DEPTH = 32;
  localparam int DEF_H_DEPTH = 16;
  function automatic logic size_ok(input int sy, input int sh, input int ymax, input int hmax);
    return sy != 0 && sh != 0 && sy <= ymax && sh <= hmax;
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: unsigned multiply-accumulate with wrap or sticky saturation of the running sum.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_s,
  input  logic              clr,
  input  logic              acc_en,
  input  logic              sat,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] acc_r;
  logic ovf;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign sum = {1'b0, acc_r} + {{(ACC_W + 1 - 2 * DATA_W){1'b0}}, prod};
  // the carry out of the wrapped sum is the overflow event; it stays set until clr
  assign acc = sat && ovf ? '1 : acc_r;
  always_ff @(posedge clk or negedge rst_a)
    if (!rst_a) begin
      acc_r <= '0;
      ovf <= 1'b0;
    end else if (en_s) begin
      if (clr) begin
        acc_r <= '0;
        ovf <= 1'b0;
      end else if (acc_en) begin
        acc_r <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
      end
    end
endmodule

// File: rtl/conv1d_engine.sv
// conv1d_engine: runtime-sized 1-D convolution z = y * h over host-loaded memories.
module conv1d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int Y_DEPTH = DEF_Y_DEPTH,
  parameter int H_DEPTH = DEF_H_DEPTH,
  localparam int Z_DEPTH = Y_DEPTH + H_DEPTH - 1,
  localparam int AW_Y = $clog2(Y_DEPTH),
  localparam int AW_H = $clog2(H_DEPTH),
  localparam int AW_Z = $clog2(Z_DEPTH),
  localparam int YSW = AW_Y + 1,
  localparam int HSW = AW_H + 1
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_s,
  input  logic              start,
  input  logic [YSW-1:0]    size_y,
  input  logic [HSW-1:0]    size_h,
  input  logic              sat_mode,
  output logic [AW_Y-1:0]   y_addr,
  input  logic [DATA_W-1:0] y_rdata,
  output logic [AW_H-1:0]   h_addr,
  input  logic [DATA_W-1:0] h_rdata,
  output logic              z_we,
  output logic [AW_Z-1:0]   z_addr,
  output logic [ACC_W-1:0]  z_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = AW_Z + 2;
  state_t state, nxt;
  logic [YSW-1:0] sy;
  logic [HSW-1:0] sh;
  logic [AW_Z-1:0] n;
  logic [DATA_W-1:0] yh, hh;
  logic [CW-1:0] n_w, sy_w, sh_w, n1, kmax, j1;
  logic sat_r, pipe_v, stl, ok, last_t, last_n;
  assign ok = size_ok(int'(size_y), int'(size_h), Y_DEPTH, H_DEPTH);
  assign n_w = CW'(n);
  assign sy_w = CW'(sy);
  assign sh_w = CW'(sh);
  assign n1 = n_w + CW'(1);
  assign kmax = n_w < sy_w ? n_w : sy_w - CW'(1);
  assign j1 = n1 < sh_w ? n1 : sh_w - CW'(1);
  assign last_t = CW'(y_addr) == kmax;
  assign last_n = n_w == sy_w + sh_w - CW'(2);
  assign busy = state != IDLE;
  assign done = state == DONE && en_s;
  assign z_we = state == WRITE && en_s;
  assign z_addr = n;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = ok ? ISSUE : DONE;
      ISSUE:   if (last_t) nxt = DRAIN;
      DRAIN:   nxt = WRITE;
      WRITE:   nxt = last_n ? DONE : ISSUE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_a)
    if (!rst_a) state <= IDLE;
    else if (en_s) state <= nxt;
  // stl/yh/hh keep the read data that was in flight when a stall began, so it is used once on resume
  always_ff @(posedge clk or negedge rst_a)
    if (!rst_a) begin
      {sy, sh, sat_r, err, n, y_addr, h_addr, pipe_v, stl, yh, hh} <= '0;
    end else begin
      stl <= !en_s;
      if (!en_s && !stl) begin
        yh <= y_rdata;
        hh <= h_rdata;
      end
      if (en_s) begin
        pipe_v <= state == ISSUE;
        case (state)
          IDLE: if (start) begin
            sy <= size_y;
            sh <= size_h;
            sat_r <= sat_mode;
            err <= !ok;
            n <= '0;
            y_addr <= '0;
            h_addr <= '0;
          end
          ISSUE: if (!last_t) begin
            y_addr <= y_addr + 1'b1;
            h_addr <= h_addr - 1'b1;
          end
          WRITE: if (!last_n) begin
            n <= n + 1'b1;
            h_addr <= AW_H'(j1);
            y_addr <= AW_Y'(n1 - j1);
          end
          default: ;
        endcase
      end
    end
  conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst_a(rst_a),
    .en_s(en_s),
    .clr((state == IDLE && start) || state == WRITE),
    .acc_en(pipe_v),
    .sat(sat_r),
    .a(stl ? yh : y_rdata),
    .b(stl ? hh : h_rdata),
    .acc(z_wdata)
  );
endmodule

// File: tb/tb_conv1d_engine.sv
// tb_conv1d_engine: randomized runs of conv1d_engine checked against a direct convolution sum.
module tb_conv1d_engine;
  localparam longint MAXV = 65535;
  logic clk = 0, rst_a = 0, en_s = 1, start = 0, sat_mode = 0;
  logic [5:0] size_y = 0;
  logic [4:0] size_h = 0;
  logic [4:0] y_addr;
  logic [3:0] h_addr;
  logic [7:0] y_rdata, h_rdata;
  logic z_we, busy, done, err;
  logic [5:0] z_addr;
  logic [15:0] z_wdata;
  logic [7:0] ymem [32];
  logic [7:0] hmem [16];
  int checks = 0, errors = 0, cyc = 0, t0 = 0, done_rel = -1, b2b = 0;
  bit done_seen = 0, err_done = 0, prev_we = 0;
  int zq_a[$];
  longint zq_d[$];

  conv1d_engine #(.DATA_W(8), .ACC_W(16), .Y_DEPTH(32), .H_DEPTH(16)) dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start), .size_y(size_y), .size_h(size_h),
    .sat_mode(sat_mode), .y_addr(y_addr), .y_rdata(y_rdata), .h_addr(h_addr), .h_rdata(h_rdata),
    .z_we(z_we), .z_addr(z_addr), .z_wdata(z_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    y_rdata <= ymem[y_addr];
    h_rdata <= hmem[h_addr];
  end
  always @(negedge clk) begin
    if (z_we) begin
      if (prev_we) b2b++;
      zq_a.push_back(int'(z_addr));
      zq_d.push_back(longint'(z_wdata));
    end
    prev_we = z_we;
    if (done) begin
      done_seen = 1;
      done_rel = cyc - t0;
      err_done = err;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_z(input int n, input int sy, input int sh, input bit sat);
    longint s = 0;
    for (int k = 0; k < sy; k++)
      if (n - k >= 0 && n - k < sh) s += longint'(ymem[k]) * longint'(hmem[n - k]);
    return sat ? (s > MAXV ? MAXV : s) : s % (MAXV + 1);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) ymem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) hmem[i] = 8'($urandom);
  endtask

  task automatic run(input int sy, input int sh, input bit sat, input int st, input int sl, input bit poke);
    bit valid;
    int nw, exp_done;
    size_y = 6'(sy);
    size_h = 5'(sh);
    sat_mode = sat;
    zq_a.delete();
    zq_d.delete();
    done_seen = 0;
    done_rel = -1;
    b2b = 0;
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 4000 && !done_seen; i++) begin
      start = (i == 0) || (poke && i == 4);
      en_s = !(sl > 0 && i >= st && i < st + sl);
      @(posedge clk); #1;
    end
    start = 0;
    en_s = 1;
    valid = sy > 0 && sh > 0 && sy <= 32 && sh <= 16;
    nw = valid ? sy + sh - 1 : 0;
    exp_done = valid ? 1 + sy * sh + 2 * nw + sl : 1;
    check("done_seen", longint'(done_seen), 1);
    check("done_cycle", done_rel, exp_done);
    check("err_at_done", longint'(err_done), longint'(!valid));
    check("err_hold", longint'(err), longint'(!valid));
    check("n_writes", zq_a.size(), nw);
    check("back_to_back", b2b, 0);
    for (int i = 0; i < zq_a.size() && i < nw; i++) begin
      check($sformatf("z_addr[%0d]", i), zq_a[i], i);
      check($sformatf("z_data[%0d]", i), zq_d[i], ref_z(i, sy, sh, sat));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_err"}, longint'(err), 0);
    check({tag, "_z_we"}, longint'(z_we), 0);
    check({tag, "_y_addr"}, longint'(y_addr), 0);
    check({tag, "_h_addr"}, longint'(h_addr), 0);
    check({tag, "_z_addr"}, longint'(z_addr), 0);
    check({tag, "_z_wdata"}, longint'(z_wdata), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ymem[i] = 0;
    for (int i = 0; i < 16; i++) hmem[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_a = 1;
    ymem[0] = 1; ymem[1] = 2; ymem[2] = 3;
    hmem[0] = 1; hmem[1] = 1;
    run(3, 2, 0, 0, 0, 0);
    check("basic_z1", zq_d.size() > 1 ? zq_d[1] : -1, 3);
    check("basic_done15", done_rel, 15);
    ymem[0] = 255; ymem[1] = 255;
    hmem[0] = 255; hmem[1] = 255;
    run(2, 2, 1, 0, 0, 0);
    check("sat_z1", zq_d.size() > 1 ? zq_d[1] : -1, 65535);
    run(2, 2, 0, 0, 0, 0);
    check("wrap_z1", zq_d.size() > 1 ? zq_d[1] : -1, 64514);
    fill_random();
    run(32, 16, 0, 0, 0, 0);
    run(32, 16, 1, 0, 0, 0);
    run(4, 0, 0, 0, 0, 0);
    run(0, 5, 0, 0, 0, 0);
    run(33, 2, 1, 0, 0, 0);
    fill_random();
    run(5, 4, 1'($urandom), 9, 5, 1);
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run(int'($urandom_range(1, 32)), int'($urandom_range(1, 16)), 1'($urandom), 0, 0, 0);
    end
    fill_random();
    size_y = 6;
    size_h = 4;
    sat_mode = 0;
    zq_a.delete();
    zq_d.delete();
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 200 && zq_a.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    check("abort_two_writes", zq_a.size(), 2);
    rst_a = 0;
    #1;
    check_reset_outputs("abort");
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_more_writes", zq_a.size(), 2);
    rst_a = 1;
    fill_random();
    run(int'($urandom_range(1, 32)), int'($urandom_range(1, 16)), 1'($urandom), 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
